// File: rtl/tcam_16x8_bank.sv
// tcam_16x8_bank: 16x8 ternary CAM with write, read, masked compare and flush
module tcam_16x8_bank #(
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int AddressSize = 4,
    parameter int BankSize    = 1
) (
    input  logic                   CK,
    input  logic                   RST,
    input  logic                   CS,
    input  logic                   FLUSH,
    input  logic                   VBE,
    input  logic                   DCS,
    input  logic                   WR,
    input  logic                   RD,
    input  logic                   CMP,
    input  logic [Bits-1:0]        DI,
    input  logic [Bits-1:0]        MSKB,
    input  logic                   VBI,
    input  logic [AddressSize-1:0] A,
    input  logic [BankSize-1:0]    CBE,
    output logic [Bits-1:0]        DO,
    output logic                   VBO,
    output logic                   HIT,
    output logic [Words-1:0]       HITLINE
);
    logic [Bits-1:0]  data [Words];
    logic [Bits-1:0]  care [Words];
    logic [Words-1:0] valid;
    logic [Words-1:0] match;
    for (genvar g = 0; g < Words; g++) begin : g_match
        assign match[g] = valid[g] && !CBE[g / (Words / BankSize)] &&
                          &(~MSKB | ~care[g] | ~(DI ^ data[g]));
    end
    always_ff @(posedge CK) begin
        if (RST) begin
            data    <= '{default: '0};
            care    <= '{default: '0};
            valid   <= '0;
            DO      <= '0;
            VBO     <= 1'b0;
            HIT     <= 1'b0;
            HITLINE <= '0;
        end else if (CS) begin
            if (FLUSH) begin
                valid   <= '0;
                HIT     <= 1'b0;
                HITLINE <= '0;
            end else if (WR) begin
                if (DCS) begin
                    data[A] <= DI;
                    care[A] <= MSKB;
                end
                if (VBE) valid[A] <= VBI;
            end else if (CMP) begin
                HITLINE <= match;
                HIT     <= |match;
            end else if (RD) begin
                DO <= DCS ? data[A] : care[A];
                if (VBE) VBO <= valid[A];
            end
        end
    end
endmodule

// File: tb/tb_tcam_16x8_bank.sv
// tb_tcam_16x8_bank: directed scoreboard bench for tcam_16x8_bank
module tb_tcam_16x8_bank;
    logic        CK = 1'b0;
    logic        RST, CS, FLUSH, VBE, DCS, WR, RD, CMP, VBI;
    logic [7:0]  DI, MSKB, DO;
    logic [3:0]  A;
    logic [0:0]  CBE;
    logic        VBO, HIT;
    logic [15:0] HITLINE;

    typedef struct {
        string       name;
        logic [7:0]  d_o;
        logic        vbo;
        logic        hit;
        logic [15:0] hl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    tcam_16x8_bank dut (
        .CK(CK), .RST(RST), .CS(CS), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS),
        .WR(WR), .RD(RD), .CMP(CMP), .DI(DI), .MSKB(MSKB), .VBI(VBI),
        .A(A), .CBE(CBE), .DO(DO), .VBO(VBO), .HIT(HIT), .HITLINE(HITLINE)
    );

    always #5 CK = ~CK;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // monitor: outputs settle after the edge, so compare on the falling edge
    initial forever begin
        @(negedge CK);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".DO"}, {8'h00, DO}, {8'h00, e.d_o});
            chk({e.name, ".VBO"}, {15'h0, VBO}, {15'h0, e.vbo});
            chk({e.name, ".HIT"}, {15'h0, HIT}, {15'h0, e.hit});
            chk({e.name, ".HITLINE"}, HITLINE, e.hl);
        end
    end

    task automatic step(input logic rst, cs, fl, wr, rd, cmp, vbe, dcs, vbi,
                        input logic [7:0] di, mskb, input logic [3:0] a, input logic cbe,
                        input string n, input logic [7:0] edo, input logic evbo, ehit,
                        input logic [15:0] ehl);
        exp_t e;
        @(negedge CK);
        RST = rst; CS = cs; FLUSH = fl; WR = wr; RD = rd; CMP = cmp;
        VBE = vbe; DCS = dcs; VBI = vbi; DI = di; MSKB = mskb; A = a; CBE = cbe;
        @(posedge CK);
        #1;
        e.name = n; e.d_o = edo; e.vbo = evbo; e.hit = ehit; e.hl = ehl;
        exp_q.push_back(e);
    endtask

    initial begin
        RST = 1; CS = 0; FLUSH = 0; WR = 0; RD = 0; CMP = 0; VBE = 0; DCS = 0;
        VBI = 0; DI = 0; MSKB = 0; A = 0; CBE = 0;
        //    rst cs fl wr rd cm vbe dcs vbi  di     mskb   a  cbe  name          DO    VBO HIT HITLINE
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, "rst0",      8'h00, 0, 0, 16'h0000);
        step(1, 1, 0, 1, 0, 0, 1, 1, 1, 8'hFF, 8'hFF, 5, 0, "rst1",      8'h00, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 5, 0, "rd_rst",    8'h00, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0, "cmp_rst",   8'h00, 0, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 1, 1, 1, 8'hA5, 8'hF0, 3, 0, "wr3",       8'h00, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 3, 0, "rd3_data",  8'hA5, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3, 0, "rd3_care",  8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 8'hA0, 8'hF0, 3, 0, "wr3_dataonly", 8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 1, 1, 0, 8'hA0, 8'hFF, 7, 0, "wr7_inval", 8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'hA0, 8'hF0, 0, 0, "cmp_a0",    8'hF0, 1, 1, 16'h0008);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'hB0, 8'hF0, 0, 0, "cmp_b0",    8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 1, 1, 1, 8'h30, 8'hF0, 2, 0, "wr2",       8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 1, 1, 1, 8'h30, 8'hF0, 9, 0, "wr9",       8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h3F, 8'hF0, 0, 0, "cmp_multi", 8'hF0, 1, 1, 16'h0204);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h3F, 8'hF0, 0, 1, "cmp_cbe",   8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h3F, 8'hF0, 0, 0, "cmp_again", 8'hF0, 1, 1, 16'h0204);
        step(0, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 2, 0, "rd_holdhit", 8'hF0, 1, 1, 16'h0204);
        step(0, 1, 1, 1, 1, 1, 1, 1, 1, 8'hEE, 8'hEE, 2, 0, "flush",     8'hF0, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 2, 0, "rd2_flushed", 8'h30, 0, 0, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 2, 0, "wr2_valid", 8'h30, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h3F, 8'hF0, 0, 0, "cmp_e2",    8'h30, 0, 1, 16'h0004);
        step(0, 1, 0, 1, 0, 1, 1, 1, 1, 8'h11, 8'hFF, 4, 0, "wr_over_cmp", 8'h30, 0, 1, 16'h0004);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h11, 8'hFF, 0, 0, "cmp_e4",    8'h30, 0, 1, 16'h0010);
        step(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 4, 0, "rd4",       8'h11, 1, 1, 16'h0010);
        step(0, 0, 1, 1, 1, 1, 1, 1, 0, 8'h22, 8'h00, 4, 0, "cs0",       8'h11, 1, 1, 16'h0010);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 4, 0, "rd4_care",  8'hFF, 1, 1, 16'h0010);
        step(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 4, 0, "rd4_after_cs0", 8'h11, 1, 1, 16'h0010);
        @(negedge CK);
        CS = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CK);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
